// File: rtl/dsp_op_sequencer_if.sv
// Command, response and DSP-side signal bundle for dsp_op_sequencer.
// The sequencer connects as slave; the command source / result sink / DSP side as master.
interface dsp_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [24:0] cmd_a;
  logic [17:0] cmd_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] dsp_a;
  logic [31:0] dsp_b;
  logic [4:0]  dsp_inmode;
  logic [6:0]  dsp_opmode;
  logic [3:0]  dsp_alumode;
  logic [31:0] dsp_p;
  logic        busy;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, dsp_p,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           dsp_a, dsp_b, dsp_inmode, dsp_opmode, dsp_alumode, busy
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready, dsp_p,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           dsp_a, dsp_b, dsp_inmode, dsp_opmode, dsp_alumode, busy
  );
endinterface

// File: rtl/dsp_op_sequencer.sv
// Command-driven front end for a fully registered DSP48E1 wrapper.
// Operands go out one cycle ahead of the control word so both meet at the
// multiplier output; results are captured after a fixed latency into a small
// FIFO, and commands are only accepted while a FIFO slot is guaranteed.
module dsp_op_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int PIPE_LAT   = 4
) (
  input logic               i_clk,
  input logic               i_rst_n,
  dsp_op_sequencer_if.slave io_seq
);
  localparam logic [0:0] ST_INIT   = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;
  localparam logic [6:0] OPM_MUL   = 7'h05;
  localparam logic [6:0] OPM_MAC_C = 7'h35;
  localparam logic [6:0] OPM_ACC   = 7'h25;
  localparam logic [6:0] OPM_CLR   = 7'h00;
  localparam logic [6:0] OPM_IDLE  = 7'h20;
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0011;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(PIPE_LAT + 1);
  localparam int SUM_W = $clog2(FIFO_DEPTH + PIPE_LAT + 1);

  logic [0:0]          r_state;
  logic [31:0]         r_dsp_a;
  logic [31:0]         r_dsp_b;
  logic [6:0]          r_pre_opmode;
  logic [3:0]          r_pre_alumode;
  logic [6:0]          r_opmode;
  logic [3:0]          r_alumode;
  logic [PIPE_LAT-1:0] r_tag_valid;
  logic [PIPE_LAT-1:0] r_tag_err;
  logic [31:0]         r_fifo_data [FIFO_DEPTH];
  logic                r_fifo_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic [IF_W-1:0]     w_inflight;
  logic                w_cmd_ready;
  logic                w_accept;
  logic [6:0]          w_dec_opmode;
  logic [3:0]          w_dec_alumode;
  logic                w_dec_err;
  logic                w_push;
  logic                w_pop;
  logic                w_rsp_valid;

  // Count commands still travelling through the DSP pipeline.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < PIPE_LAT; i++) begin
      w_inflight = w_inflight + IF_W'(r_tag_valid[i]);
    end
  end

  // Credit: every accepted command must find a free FIFO slot when it lands.
  assign w_cmd_ready = (r_state == ST_RUN) &&
                       ((SUM_W'(w_inflight) + SUM_W'(r_count)) < SUM_W'(FIFO_DEPTH));
  assign w_accept    = io_seq.cmd_valid & w_cmd_ready;

  // Translate the command opcode into DSP control; illegal ops just hold P.
  always_comb begin
    w_dec_opmode  = OPM_IDLE;
    w_dec_alumode = ALU_ADD;
    w_dec_err     = 1'b0;
    case (io_seq.cmd_op)
      3'd0: w_dec_opmode = OPM_MUL;
      3'd1: w_dec_opmode = OPM_MAC_C;
      3'd2: w_dec_opmode = OPM_ACC;
      3'd3: begin
        w_dec_opmode  = OPM_ACC;
        w_dec_alumode = ALU_SUB;
      end
      3'd4: w_dec_opmode = OPM_CLR;
      default: w_dec_err = 1'b1;
    endcase
  end

  // INIT lasts exactly one cycle after reset, then the sequencer runs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_INIT;
    else          r_state <= ST_RUN;
  end

  // Operand stage and staged control word; INIT stages a clear, bubbles stage IDLE.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dsp_a       <= '0;
      r_dsp_b       <= '0;
      r_pre_opmode  <= OPM_CLR;
      r_pre_alumode <= ALU_ADD;
    end else begin
      if (w_accept) begin
        r_dsp_a <= {{7{io_seq.cmd_a[24]}}, io_seq.cmd_a};
        r_dsp_b <= {{14{io_seq.cmd_b[17]}}, io_seq.cmd_b};
      end
      if (r_state == ST_INIT) begin
        r_pre_opmode  <= OPM_CLR;
        r_pre_alumode <= ALU_ADD;
      end else if (w_accept) begin
        r_pre_opmode  <= w_dec_opmode;
        r_pre_alumode <= w_dec_alumode;
      end else begin
        r_pre_opmode  <= OPM_IDLE;
        r_pre_alumode <= ALU_ADD;
      end
    end
  end

  // Control output one cycle behind the operands so it lines up with M.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opmode  <= OPM_CLR;
      r_alumode <= ALU_ADD;
    end else begin
      r_opmode  <= r_pre_opmode;
      r_alumode <= r_pre_alumode;
    end
  end

  // Tag pipe marks which cycles carry a result and whether it is an error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tag_valid <= '0;
      r_tag_err   <= '0;
    end else begin
      r_tag_valid <= {r_tag_valid[PIPE_LAT-2:0], w_accept};
      r_tag_err   <= {r_tag_err[PIPE_LAT-2:0], w_accept & w_dec_err};
    end
  end

  assign w_push      = r_tag_valid[PIPE_LAT-1];
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & io_seq.rsp_ready;

  // Result storage; error results are stored as zero.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_tag_err[PIPE_LAT-1] ? 32'd0 : io_seq.dsp_p;
      r_fifo_err[r_wr_ptr]  <= r_tag_err[PIPE_LAT-1];
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop both take effect.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit rule makes overflow impossible; flag it if that ever breaks.
  a_fifo_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(w_push && !w_pop && (r_count == CNT_W'(FIFO_DEPTH))));

  assign io_seq.cmd_ready   = w_cmd_ready;
  assign io_seq.rsp_valid   = w_rsp_valid;
  assign io_seq.rsp_data    = w_rsp_valid ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign io_seq.rsp_err     = w_rsp_valid & r_fifo_err[r_rd_ptr];
  assign io_seq.dsp_a       = r_dsp_a;
  assign io_seq.dsp_b       = r_dsp_b;
  assign io_seq.dsp_inmode  = 5'b00000;
  assign io_seq.dsp_opmode  = r_opmode;
  assign io_seq.dsp_alumode = r_alumode;
  assign io_seq.busy        = (r_state == ST_INIT) | (w_inflight != '0) | w_rsp_valid;
endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Bench for dsp_op_sequencer: directed commands against a registered DSP48E1
// model; expected results are queued at command accept and checked in order
// by a monitor whenever a response handshake occurs.
module tb_dsp_op_sequencer;
  logic clk;
  logic rst_n;

  dsp_op_sequencer_if bus();

  dsp_op_sequencer #(.FIFO_DEPTH(4), .PIPE_LAT(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_seq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DSP48E1 behaviour: AREG/BREG, MREG, ctrl reg and PREG all one stage.
  localparam logic signed [47:0] C_CONST = 48'h95514;
  logic signed [47:0] a_reg = '0;
  logic signed [47:0] b_reg = '0;
  logic signed [47:0] m_reg = '0;
  logic signed [47:0] p_reg = '0;
  logic [6:0]         opm_reg = 7'h20;
  logic [3:0]         alu_reg = 4'h0;

  always @(posedge clk) begin
    a_reg   <= {{16{bus.dsp_a[31]}}, bus.dsp_a};
    b_reg   <= {{16{bus.dsp_b[31]}}, bus.dsp_b};
    m_reg   <= a_reg * b_reg;
    opm_reg <= bus.dsp_opmode;
    alu_reg <= bus.dsp_alumode;
    case ({opm_reg, alu_reg})
      {7'h05, 4'h0}: p_reg <= m_reg;
      {7'h35, 4'h0}: p_reg <= C_CONST + m_reg;
      {7'h25, 4'h0}: p_reg <= p_reg + m_reg;
      {7'h25, 4'h3}: p_reg <= p_reg - m_reg;
      {7'h00, 4'h0}: p_reg <= '0;
      default:       p_reg <= p_reg;
    endcase
  end
  assign bus.dsp_p = p_reg[31:0];

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_acc   = 0;
  int   next_id = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("[TB] %s ok: %h", name, act);
    end
  endtask

  // Response checker and accept counter, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.cmd_valid && bus.cmd_ready) n_acc++;
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got data=%h err=%b required no response",
                   bus.rsp_data, bus.rsp_err);
        end else begin
          e = exp_q.pop_front();
          if (bus.rsp_data !== e.data || bus.rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL rsp#%0d: got data=%h err=%b required data=%h err=%b",
                     e.id, bus.rsp_data, bus.rsp_err, e.data, e.err);
          end else begin
            $display("[TB] rsp#%0d ok: data=%h err=%b", e.id, bus.rsp_data, bus.rsp_err);
          end
        end
      end
    end
  endtask

  // Offer one command until accepted; queue its expected response on accept.
  task automatic send(input logic [2:0] op, input int a, input int b,
                      input logic [31:0] ed, input logic ee);
    bit   acc;
    int   guard;
    exp_t e;
    guard         = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a[24:0];
    bus.cmd_b     = b[17:0];
    forever begin
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      guard++;
      if (guard > 200) break;
    end
    bus.cmd_valid = 1'b0;
    if (acc) begin
      e.data = ed;
      e.err  = ee;
      e.id   = next_id;
      exp_q.push_back(e);
      $display("[TB] cmd#%0d op=%0d a=%0d b=%0d accepted", next_id, op, a, b);
      next_id++;
    end else begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_accept_timeout: got cmd_ready=0 for 200 cycles required accept (op=%0d)", op);
    end
  endtask

  // Wait for all outstanding work to retire.
  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_drain_timeout: got busy=1 after 100 cycles required 0", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish within 200us");
    $fatal(1);
  end

  initial begin
    int  lat;
    int  base;
    bit  seen;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b1;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_opmode", {25'd0, bus.dsp_opmode}, 32'h00);
    chk("rst_dsp_a", bus.dsp_a, 32'd0);
    chk("rst_alumode", {28'd0, bus.dsp_alumode}, 32'd0);
    rst_n = 1'b1;
    chk("init_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("run_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // T1: MUL with latency check
    send(3'd0, 3, 5, 32'd15, 1'b0);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.rsp_valid) break;
    end
    chk("t1_latency", lat, 32'd4);
    drain("t1");

    // T2: MAC_C
    send(3'd1, 2, 3, 32'h0009551A, 1'b0);
    drain("t2");

    // T3: accumulate back-to-back, then with gaps
    send(3'd4, 0, 0, 32'd0, 1'b0);
    send(3'd2, 2, 3, 32'd6, 1'b0);
    send(3'd2, 4, 5, 32'd26, 1'b0);
    drain("t3a");
    send(3'd4, 0, 0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(3'd2, 2, 3, 32'd6, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    send(3'd2, 4, 5, 32'd26, 1'b0);
    drain("t3b");

    // T4: subtract-accumulate and negative multiply
    send(3'd4, 0, 0, 32'd0, 1'b0);
    send(3'd3, 1, 1, 32'hFFFFFFFF, 1'b0);
    send(3'd0, -2, 3, 32'hFFFFFFFA, 1'b0);
    drain("t4");

    // T5: backpressure limits outstanding commands to the FIFO depth
    bus.rsp_ready = 1'b0;
    base = n_acc;
    fork
      begin
        for (int i = 0; i < 8; i++) send(3'd0, i + 1, 3, 32'(3 * (i + 1)), 1'b0);
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("t5_accepted", n_acc - base, 32'd4);
        chk("t5_cmd_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
      end
    join
    drain("t5");

    // T6: illegal op in the middle, then reset with commands in flight
    send(3'd0, 7, 7, 32'd49, 1'b0);
    send(3'd6, 9, 9, 32'd0, 1'b1);
    send(3'd0, 3, -4, 32'hFFFFFFF4, 1'b0);
    drain("t6a");
    send(3'd0, 5, 5, 32'd25, 1'b0);
    send(3'd0, 6, 6, 32'd36, 1'b0);
    send(3'd0, 8, 8, 32'd64, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    $display("[TB] reset asserted with 3 commands in flight");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    chk("t6_no_stale_rsp", {31'd0, seen}, 32'd0);
    send(3'd2, 2, 2, 32'd4, 1'b0);
    drain("t6b");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
